riscv_dram_port_arbiter: RTL and testbench
==========================================

Name: riscv_dram_port_arbiter

Overview:
- Two-requester arbiter sharing the single-port, byte-writable DRAM block RAM between the CPU data port (requester A) and a DMA/debug master (requester B).
- Selects one request per cycle and drives the RAM enable/address/data/strobe pins.
- Tracks the 1-cycle RAM read latency and routes the response (rvalid/rdata/err) back to the winner.
- Rejects out-of-window addresses without touching the RAM.

Parameters:
- DATA_WIDTH, 32, data width; 33 when a capability tag bit is carried.
- DRAM_DEPTH, 'h4000, RAM depth in words.
- BASE_ADDR, 32'h2000_0000, byte base address of the DRAM window.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority to A with starvation guard.
- STARVE_LIMIT, 8, max consecutive cycles B may wait in PRIO_MODE=1 before it is forced through; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- a_req_i  in  1  A request; held with its payload stable until a_gnt_o
- a_addr_i  in  32  A byte address
- a_we_i  in  1  A write
- a_be_i  in  4  A byte enables
- a_wdata_i  in  DATA_WIDTH  A write data
- a_gnt_o  out  1  A accepted this cycle
- a_rvalid_o  out  1  A response valid (read data or write ack)
- a_rdata_o  out  DATA_WIDTH  A read data
- a_err_o  out  1  A address error; qualified by a_rvalid_o
- b_req_i, b_addr_i, b_we_i, b_be_i, b_wdata_i, b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o: same as A, for B
- mem_en_o  out  1  RAM chip select
- mem_addr_o  out  $clog2(DRAM_DEPTH)  RAM word address
- mem_we_o  out  1  RAM write
- mem_wstrb_o  out  DATA_WIDTH  per-bit strobe: bit DATA_WIDTH-1 = 1 when DATA_WIDTH==33; bytes k = {8{be[k]}}
- mem_wdata_o  out  DATA_WIDTH  RAM write data
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after mem_en_o with mem_we_o=0

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i synchronous, active-high.
- Acceptance: a transaction is accepted when x_req_i & x_gnt_o. Grants are combinational from the requests and the registered arbitration state. At most one grant per cycle. No grants while rst_i=1.
- Arbitration, PRIO_MODE=0:
  - Registered pointer prio_b (reset 0 = A favoured).
  - Both requesting: winner is B if prio_b, else A.
  - After any grant, prio_b is set to (winner==A).
  - A single requester always wins.
- Arbitration, PRIO_MODE=1:
  - A wins ties unless starve_cnt == STARVE_LIMIT, in which case B wins.
  - starve_cnt increments when b_req_i is high and B is not granted, saturating at STARVE_LIMIT.
  - starve_cnt clears on a B grant or when b_req_i is low. Reset value 0.
- Window check:
  - offset = addr - BASE_ADDR, 32-bit modulo.
  - In range iff offset < DRAM_DEPTH*4.
  - In range: mem_en_o=1, mem_addr_o = offset[AW+1:2], mem_we_o/mem_wdata_o/mem_wstrb_o from the winner. All in the grant cycle; no added latency.
  - Out of range: still granted; mem_en_o=0.
- Response pipeline:
  - One register stage holds {valid, owner, is_read, err}.
  - Cycle after grant: x_rvalid_o=1 for the owner only.
  - x_rdata_o = mem_rdata_i for in-range reads, else 0.
  - x_err_o=1 if out of range.
  - Writes complete in 1 cycle.
- Throughput: back-to-back grants every cycle are allowed, including alternating owners; the response stage is overwritten each cycle.
- Idle outputs: mem_en_o=0. mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o are 0 when no grant.
- Reset values: all gnt/rvalid/err/rdata outputs 0, mem_* 0, prio_b 0, starve_cnt 0.
- Reset mid-operation: a response due the cycle after reset asserts is dropped; no rvalid is emitted.
- Withdrawing a request before grant is a protocol violation. The bench asserts on it; the RTL takes no action.

Decomposition:
- Shared package riscv_mem_pkg:
  - typedef req_id_e {REQ_A, REQ_B}
  - typedef resp_s {valid, owner, is_read, err}
  - function be_to_wstrb(be, DATA_WIDTH)
  - localparam AW = $clog2(DRAM_DEPTH)
- One sub-module, riscv_rr_arb2: the 2-way grant logic with pointer and starvation counter, parameterised by PRIO_MODE and STARVE_LIMIT.

Test Plan:
- Single A read at BASE_ADDR+'h10 holding word 'hDEADBEEF: a_gnt_o same cycle, mem_addr_o=4, a_rvalid_o next cycle with a_rdata_o='hDEADBEEF, b_rvalid_o=0.
- A write be=4'b0010, wdata='h0000AB00 to word 4, then B read of word 4 (init 'h11223344): mem_wstrb_o bits [15:8] set only; B reads 'h1122AB44.
- PRIO_MODE=0, both requesting continuously for 6 cycles: grants A,B,A,B,A,B; each rvalid goes to the correct owner.
- PRIO_MODE=1, STARVE_LIMIT=3, A and B both requesting continuously: A granted 3 cycles, B granted cycle 4, A granted again on the next cycle.
- B read at BASE_ADDR+DRAM_DEPTH*4: b_gnt_o=1, mem_en_o=0, next cycle b_rvalid_o=1, b_err_o=1, b_rdata_o=0.
- rst_i asserted the cycle after an A grant: no a_rvalid_o; after release, prio_b=0 and all outputs 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the DRAM port arbiter slice.
package riscv_mem_pkg;

  localparam int unsigned DefaultDramDepth = 'h4000;
  localparam int unsigned AW = $clog2(DefaultDramDepth);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e owner;
    logic    is_read;
    logic    err;
  } resp_s;

  // Bit 32 is the capability tag lane, always written when the tag is carried.
  function automatic logic [32:0] be_to_wstrb(input logic [3:0] be,
                                               input int unsigned data_width);
    logic [32:0] strb;
    strb = '0;
    for (int k = 0; k < 4; k++) begin
      strb[8*k +: 8] = {8{be[k]}};
    end
    if (data_width == 33) begin
      strb[32] = 1'b1;
    end
    return strb;
  endfunction

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way grant logic: round-robin pointer or fixed priority to A with a starvation guard for B.
module riscv_rr_arb2 #(
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic            prio_b_q;
  logic [CntW-1:0] starve_cnt_q;
  logic            b_wins;

  always_comb begin
    if (PRIO_MODE == 0) begin
      b_wins = b_req_i & (~a_req_i | prio_b_q);
    end else begin
      b_wins = b_req_i & (~a_req_i | (starve_cnt_q == Limit));
    end
    b_gnt_o = b_wins & ~rst_i;
    a_gnt_o = a_req_i & ~b_wins & ~rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_b_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      if (a_gnt_o | b_gnt_o) begin
        prio_b_q <= a_gnt_o;
      end
      if (!b_req_i || b_gnt_o) begin
        starve_cnt_q <= '0;
      end else if (starve_cnt_q != Limit) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_dram_port_arbiter.sv
// Shares the single-port DRAM between the CPU data port (A) and a DMA/debug master (B),
// window-checks addresses and routes the one-cycle read response back to the winner.
module riscv_dram_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DRAM_DEPTH   = 'h4000,
  parameter logic [31:0] BASE_ADDR    = 32'h2000_0000,
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          a_req_i,
  input  logic [31:0]                   a_addr_i,
  input  logic                          a_we_i,
  input  logic [3:0]                    a_be_i,
  input  logic [DATA_WIDTH-1:0]         a_wdata_i,
  output logic                          a_gnt_o,
  output logic                          a_rvalid_o,
  output logic [DATA_WIDTH-1:0]         a_rdata_o,
  output logic                          a_err_o,
  input  logic                          b_req_i,
  input  logic [31:0]                   b_addr_i,
  input  logic                          b_we_i,
  input  logic [3:0]                    b_be_i,
  input  logic [DATA_WIDTH-1:0]         b_wdata_i,
  output logic                          b_gnt_o,
  output logic                          b_rvalid_o,
  output logic [DATA_WIDTH-1:0]         b_rdata_o,
  output logic                          b_err_o,
  output logic                          mem_en_o,
  output logic [$clog2(DRAM_DEPTH)-1:0] mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_WIDTH-1:0]         mem_wstrb_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

  localparam int unsigned MemAw = $clog2(DRAM_DEPTH);
  localparam logic [32:0] WinBytes = 33'(DRAM_DEPTH) << 2;

  logic                  a_gnt, b_gnt, granted, in_range;
  logic [31:0]           sel_addr, offset;
  logic                  sel_we;
  logic [3:0]            sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata, rd_data;
  logic                  rsp_live, a_hit, b_hit;
  resp_s                 resp_d, resp_q;

  riscv_rr_arb2 #(
    .PRIO_MODE   (PRIO_MODE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_req_i(a_req_i),
    .b_req_i(b_req_i),
    .a_gnt_o(a_gnt),
    .b_gnt_o(b_gnt)
  );

  assign a_gnt_o = a_gnt;
  assign b_gnt_o = b_gnt;

  always_comb begin
    granted   = a_gnt | b_gnt;
    sel_addr  = b_gnt ? b_addr_i  : a_addr_i;
    sel_we    = b_gnt ? b_we_i    : a_we_i;
    sel_be    = b_gnt ? b_be_i    : a_be_i;
    sel_wdata = b_gnt ? b_wdata_i : a_wdata_i;
    // Modulo subtraction folds addresses below the base into a huge offset.
    offset    = sel_addr - BASE_ADDR;
    in_range  = ({1'b0, offset} < WinBytes);

    mem_en_o    = granted & in_range;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (mem_en_o) begin
      mem_addr_o  = offset[MemAw+1:2];
      mem_we_o    = sel_we;
      mem_wdata_o = sel_wdata;
      mem_wstrb_o = DATA_WIDTH'(be_to_wstrb(sel_be, DATA_WIDTH));
    end

    resp_d.valid   = granted;
    resp_d.owner   = b_gnt ? REQ_B : REQ_A;
    resp_d.is_read = ~sel_we;
    resp_d.err     = ~in_range;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Gating with rst_i drops a response that lands in the first reset cycle.
  always_comb begin
    rsp_live   = resp_q.valid & ~rst_i;
    a_hit      = rsp_live & (resp_q.owner == REQ_A);
    b_hit      = rsp_live & (resp_q.owner == REQ_B);
    rd_data    = (resp_q.is_read & ~resp_q.err) ? mem_rdata_i : '0;
    a_rvalid_o = a_hit;
    a_err_o    = a_hit & resp_q.err;
    a_rdata_o  = a_hit ? rd_data : '0;
    b_rvalid_o = b_hit;
    b_err_o    = b_hit & resp_q.err;
    b_rdata_o  = b_hit ? rd_data : '0;
  end

endmodule

// File: tb/tb_riscv_dram_port_arbiter.sv
// Directed bench for the DRAM port arbiter: round-robin DUT plus a fixed-priority twin,
// checked every cycle against a transaction-level model.
module tb_riscv_dram_port_arbiter;

  localparam int unsigned DEPTH  = 'h4000;
  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam int unsigned STARVE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_be, b_be;

  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wstrb, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        p_a_gnt, p_a_rvalid, p_a_err, p_b_gnt, p_b_rvalid, p_b_err;
  logic [31:0] p_a_rdata, p_b_rdata;
  logic        p_mem_en, p_mem_we;
  logic [13:0] p_mem_addr;
  logic [31:0] p_mem_wstrb, p_mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram [64];

  always #5 clk = ~clk;

  riscv_dram_port_arbiter #(
    .DATA_WIDTH(32), .DRAM_DEPTH(DEPTH), .BASE_ADDR(BASE), .PRIO_MODE(0), .STARVE_LIMIT(8)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_we_i(a_we), .a_be_i(a_be), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_we_i(b_we), .b_be_i(b_be), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wstrb_o(mem_wstrb),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  riscv_dram_port_arbiter #(
    .DATA_WIDTH(32), .DRAM_DEPTH(DEPTH), .BASE_ADDR(BASE), .PRIO_MODE(1), .STARVE_LIMIT(STARVE)
  ) u_prio (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_we_i(a_we), .a_be_i(a_be), .a_wdata_i(a_wdata),
    .a_gnt_o(p_a_gnt), .a_rvalid_o(p_a_rvalid), .a_rdata_o(p_a_rdata), .a_err_o(p_a_err),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_we_i(b_we), .b_be_i(b_be), .b_wdata_i(b_wdata),
    .b_gnt_o(p_b_gnt), .b_rvalid_o(p_b_rvalid), .b_rdata_o(p_b_rdata), .b_err_o(p_b_err),
    .mem_en_o(p_mem_en), .mem_addr_o(p_mem_addr), .mem_we_o(p_mem_we), .mem_wstrb_o(p_mem_wstrb),
    .mem_wdata_o(p_mem_wdata), .mem_rdata_i(32'h0)
  );

  function automatic logic [31:0] init_word(input int w);
    return (w == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(w);
  endfunction

  // Block RAM behind the round-robin DUT; reloaded whenever reset is held.
  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 64; w++) ram[w] <= init_word(w);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[5:0]] <= (ram[mem_addr[5:0]] & ~mem_wstrb) | (mem_wdata & mem_wstrb);
      else        mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model, evaluated mid-cycle while inputs are stable.
  logic [31:0] shadow [64];
  logic        last_win_a = 1'b0;
  int          b_waited   = 0;
  logic        pv = 1'b0, pb = 1'b0, perr = 1'b0, prd = 1'b0;
  logic [31:0] pdata = '0;
  logic        ppv = 1'b0, ppb = 1'b0;
  logic        a_owes = 1'b0, b_owes = 1'b0;

  always @(negedge clk) begin : model
    logic        ega, egb, pga, pgb, inwin, we, live, plive;
    logic [31:0] addr, off, wd, strb;
    logic [3:0]  be;
    int          w;
    if (rst) begin
      ega = 1'b0; egb = 1'b0;
    end else if (a_req && b_req) begin
      egb = last_win_a; ega = !last_win_a;
    end else begin
      ega = a_req; egb = b_req;
    end
    pgb = !rst && b_req && (!a_req || b_waited == STARVE);
    pga = !rst && a_req && !pgb;

    addr  = egb ? b_addr : a_addr;
    we    = egb ? b_we : a_we;
    be    = egb ? b_be : a_be;
    wd    = egb ? b_wdata : a_wdata;
    off   = addr - BASE;
    inwin = 64'(off) < 64'(DEPTH) * 4;
    w     = int'(off[7:2]);
    strb  = '0;
    for (int k = 0; k < 4; k++) if (be[k]) strb[8*k +: 8] = 8'hFF;

    chk("a_gnt", a_gnt, ega);
    chk("b_gnt", b_gnt, egb);
    chk("mem_en", mem_en, (ega || egb) && inwin);
    if ((ega || egb) && inwin) begin
      chk("mem_addr", mem_addr, off[15:2]);
      chk("mem_we", mem_we, we);
      chk("mem_wdata", mem_wdata, wd);
      chk("mem_wstrb", mem_wstrb, strb);
    end else begin
      chk("idle_mem", {mem_addr, mem_we, mem_wdata, mem_wstrb}, 0);
    end

    live = !rst && pv;
    chk("a_rvalid", a_rvalid, live && !pb);
    chk("b_rvalid", b_rvalid, live && pb);
    chk("a_err", a_err, live && !pb && perr);
    chk("b_err", b_err, live && pb && perr);
    chk("a_rdata", a_rdata, (live && !pb && prd && !perr) ? pdata : 32'h0);
    chk("b_rdata", b_rdata, (live && pb && prd && !perr) ? pdata : 32'h0);

    plive = !rst && ppv;
    chk("p_a_gnt", p_a_gnt, pga);
    chk("p_b_gnt", p_b_gnt, pgb);
    chk("p_a_rvalid", p_a_rvalid, plive && !ppb);
    chk("p_b_rvalid", p_b_rvalid, plive && ppb);

    if (!rst) begin
      assert (!(a_owes && !a_req)) else $error("protocol: A dropped request before grant");
      assert (!(b_owes && !b_req)) else $error("protocol: B dropped request before grant");
    end

    if (rst) begin
      last_win_a = 1'b0; b_waited = 0; pv = 1'b0; ppv = 1'b0;
      a_owes = 1'b0; b_owes = 1'b0;
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    end else begin
      if (ega || egb) last_win_a = ega;
      if (!b_req || pgb) b_waited = 0;
      else if (b_waited < STARVE) b_waited++;
      a_owes = a_req && !ega;
      b_owes = b_req && !egb;
      pv    = ega || egb;
      pb    = egb;
      perr  = !inwin;
      prd   = !we;
      pdata = inwin ? shadow[w] : 32'h0;
      if ((ega || egb) && inwin && we) shadow[w] = (shadow[w] & ~strb) | (wd & strb);
      ppv = pga || pgb;
      ppb = pgb;
    end
  end

  task automatic set_a(input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    a_req = req; a_addr = addr; a_we = we; a_be = be; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    b_req = req; b_addr = addr; b_we = we; b_be = be; b_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    repeat (2) next_cycle();

    // Request during reset is not granted.
    set_a(1, BASE + 32'h10, 0, 4'hF, 0);
    @(negedge clk);
    chk("rst_no_gnt", a_gnt, 0);

    // Single A read of word 4.
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("t1_a_gnt", a_gnt, 1);
    chk("t1_mem_addr", mem_addr, 4);
    next_cycle(); set_a(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_a_rvalid", a_rvalid, 1);
    chk("t1_a_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("t1_b_rvalid", b_rvalid, 0);

    // B seeds word 4, A merges one byte, B reads back.
    next_cycle(); set_b(1, BASE + 32'h10, 1, 4'hF, 32'h1122_3344);
    next_cycle(); set_b(0, 0, 0, 0, 0); set_a(1, BASE + 32'h10, 1, 4'b0010, 32'h0000_AB00);
    @(negedge clk);
    chk("t2_wstrb", mem_wstrb, 32'h0000_FF00);
    chk("t2_we", mem_we, 1);
    next_cycle(); set_a(0, 0, 0, 0, 0); set_b(1, BASE + 32'h10, 0, 4'hF, 0);
    next_cycle(); set_b(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_b_rdata", b_rdata, 32'h1122_AB44);

    // Round-robin: both requesting, grants alternate starting with A.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      set_a(i < 5, BASE + 32'(4 * (8 + (i + 1) / 2)), 0, 4'hF, 0);
      set_b(1, BASE + 32'(4 * (20 + i / 2)), 1, 4'hF, 32'hB0B0_0000 + 32'(i / 2));
      @(negedge clk);
      chk("rr_a_gnt", a_gnt, i % 2 == 0);
      chk("rr_b_gnt", b_gnt, i % 2 == 1);
      if (i > 0) chk("rr_a_rvalid", a_rvalid, i % 2 == 0 ? 1'b0 : 1'b1);
    end
    next_cycle(); set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);

    // Fixed priority twin: A three times, B forced through, then A again.
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      set_a(1, BASE + 32'h20, 0, 4'hF, 0);
      set_b(i < 6, BASE + 32'h24, 0, 4'hF, 0);
      @(negedge clk);
      chk("prio_a_gnt", p_a_gnt, i != 3);
      chk("prio_b_gnt", p_b_gnt, i == 3);
    end
    next_cycle(); set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);

    // First byte past the window.
    next_cycle(); set_b(1, BASE + 32'(DEPTH * 4), 0, 4'hF, 0);
    @(negedge clk);
    chk("oor_b_gnt", b_gnt, 1);
    chk("oor_mem_en", mem_en, 0);
    next_cycle(); set_b(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("oor_b_rvalid", b_rvalid, 1);
    chk("oor_b_err", b_err, 1);
    chk("oor_b_rdata", b_rdata, 0);

    // Reset right after an A grant drops its response and clears the pointer.
    next_cycle(); set_a(1, BASE + 32'h10, 0, 4'hF, 0);
    @(negedge clk);
    chk("rst_mid_a_gnt", a_gnt, 1);
    next_cycle(); set_a(0, 0, 0, 0, 0); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_rvalid", a_rvalid, 0);
    next_cycle(); rst = 1'b0;
    set_a(1, BASE + 32'h14, 0, 4'hF, 0);
    set_b(1, BASE + 32'h18, 0, 4'hF, 0);
    @(negedge clk);
    chk("post_rst_a_first", a_gnt, 1);
    chk("post_rst_b_waits", b_gnt, 0);
    next_cycle(); set_a(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_b_gnt", b_gnt, 1);
    next_cycle(); set_b(0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("idle_en", mem_en, 0);
    chk("idle_rvalid", {a_rvalid, b_rvalid}, 0);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
